// File: rtl/data_bus_responder_if.sv
// data_bus_responder_if: LSU data-side bus between the core and the data responder.
interface data_bus_responder_if;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic [3:0]  wstrb;
   logic [31:0] dRdata;
   modport master (output dAddr, output dWdata, output wstrb, input dRdata);
   modport slave (input dAddr, input dWdata, input wstrb, output dRdata);
endinterface

// File: rtl/data_bus_responder.sv
// data_bus_responder: word RAM plus MMIO block (GPO, compare timer with sticky match/irq).
// Reads are combinational; writes, counting and flag updates happen on the clock edge.
module data_bus_responder #(
   parameter int          RAM_DEPTH = 256,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   data_bus_responder_if.slave        bus,
   output logic [31:0]                gpo,
   output logic                       timer_irq
);
   localparam int AW = $clog2(RAM_DEPTH);
   logic [31:0] mem_q [RAM_DEPTH];
   logic [31:0] gpo_q, gpo_d, cnt_q, cnt_d, cmp_q, cmp_d, wd, mmio_rd;
   logic [2:0]  ctrl_q, ctrl_d, off;
   logic        match_q, match_d, ram_hit, mmio_hit, wr, hit_cmp;
   logic [AW-1:0] idx;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i+:8] = s[i] ? nw[8*i+:8] : old[8*i+:8];
      return r;
   endfunction

   assign ram_hit  = bus.dAddr < 32'(RAM_DEPTH * 4);
   assign mmio_hit = bus.dAddr[31:5] == MMIO_BASE[31:5];
   assign idx      = bus.dAddr[AW+1:2];
   assign off      = bus.dAddr[4:2];
   assign wr       = mmio_hit && |bus.wstrb;
   // Halfword stores replicate into both halves, byte stores into all lanes; the strobe picks.
   assign wd = (bus.wstrb == 4'b0011 || bus.wstrb == 4'b1100) ? {2{bus.dWdata[15:0]}} :
               $onehot(bus.wstrb) ? {4{bus.dWdata[7:0]}} : bus.dWdata;

   assign mmio_rd = off == 3'd0 ? gpo_q :
                    off == 3'd1 ? cnt_q :
                    off == 3'd2 ? cmp_q :
                    off == 3'd3 ? {29'b0, ctrl_q} :
                    off == 3'd4 ? {31'b0, match_q} : '0;
   assign bus.dRdata = ram_hit ? mem_q[idx] : mmio_hit ? mmio_rd : '0;
   assign gpo        = gpo_q;
   assign timer_irq  = match_q & ctrl_q[2];
   assign hit_cmp    = ctrl_q[0] && cnt_q == cmp_q;

   always_comb begin
      gpo_d   = (wr && off == 3'd0) ? merge(gpo_q, wd, bus.wstrb) : gpo_q;
      cmp_d   = (wr && off == 3'd2) ? merge(cmp_q, wd, bus.wstrb) : cmp_q;
      ctrl_d  = (wr && off == 3'd3 && bus.wstrb[0]) ? wd[2:0] : ctrl_q;
      cnt_d   = (wr && off == 3'd1) ? merge(cnt_q, wd, bus.wstrb) :
                (hit_cmp && ctrl_q[1]) ? '0 :
                ctrl_q[0] ? cnt_q + 32'd1 : cnt_q;
      // A new match outranks a same-cycle W1C, and a CNT write suppresses the match.
      match_d = (hit_cmp && !(wr && off == 3'd1)) ||
                (match_q && !(wr && off == 3'd4 && bus.wstrb[0] && wd[0]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpo_q   <= '0;
         cnt_q   <= '0;
         cmp_q   <= '1;
         ctrl_q  <= '0;
         match_q <= 1'b0;
      end else begin
         gpo_q   <= gpo_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         match_q <= match_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && ram_hit)
         for (int i = 0; i < 4; i++)
            if (bus.wstrb[i]) mem_q[idx][8*i+:8] <= wd[8*i+:8];
   end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed stimulus with a queued scoreboard checked by a probe-driven monitor.
module tb_data_bus_responder;
   localparam logic [31:0] MB = 32'h1000_0000;
   localparam int K_RD = 0, K_GPO = 1, K_IRQ = 2;

   typedef struct {
      int          k;
      logic [31:0] e;
      string       n;
   } item_t;

   logic        clk, reset, probe;
   logic [31:0] gpo;
   logic        timer_irq;
   item_t       q[$];
   int          checks = 0;
   int          errors = 0;

   data_bus_responder_if bus ();

   data_bus_responder #(.RAM_DEPTH(256), .MMIO_BASE(MB)) dut (
      .clk(clk), .reset(reset), .bus(bus), .gpo(gpo), .timer_irq(timer_irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   always @(posedge probe) begin : mon
      item_t       it;
      logic [31:0] act;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard empty on probe");
      end else begin
         it  = q.pop_front();
         act = it.k == K_GPO ? gpo : it.k == K_IRQ ? {31'b0, timer_irq} : bus.dRdata;
         checks++;
         if (act !== it.e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", it.n, act, it.e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.dAddr  = a;
      bus.dWdata = d;
      bus.wstrb  = s;
      tick();
      bus.wstrb  = 4'b0000;
   endtask

   task automatic chk(input int k, input logic [31:0] a, input logic [31:0] e, input string n);
      item_t it;
      bus.dAddr = a;
      bus.wstrb = 4'b0000;
      it.k = k;
      it.e = e;
      it.n = n;
      q.push_back(it);
      #1 probe = 1'b1;
      #1 probe = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      probe = 1'b0;
      bus.dAddr = '0;
      bus.dWdata = '0;
      bus.wstrb = '0;
      tick();
      tick();
      chk(K_GPO, 0, 32'h0, "rst_gpo");
      chk(K_IRQ, 0, 32'h0, "rst_irq");
      reset = 1'b0;
      chk(K_RD, MB + 8, 32'hFFFF_FFFF, "rst_cmp");
      chk(K_RD, MB + 4, 32'h0, "rst_cnt");
      chk(K_RD, MB + 12, 32'h0, "rst_ctrl");
      chk(K_RD, MB + 16, 32'h0, "rst_status");
      // RAM lane steering
      wr(32'h40, 32'h1122_3344, 4'b1111);
      wr(32'h40, 32'h0000_00AB, 4'b0100);
      wr(32'h40, 32'h0000_CDEF, 4'b0011);
      chk(K_RD, 32'h40, 32'h11AB_CDEF, "ram_sb_sh");
      wr(32'h40, 32'h0000_5566, 4'b1100);
      chk(K_RD, 32'h40, 32'h5566_CDEF, "ram_sh_hi");
      chk(K_RD, 32'h42, 32'h5566_CDEF, "ram_aligned");
      wr(32'h44, 32'h0, 4'b1111);
      wr(32'h44, 32'h0000_0077, 4'b1000);
      chk(K_RD, 32'h44, 32'h7700_0000, "ram_sb_lane3");
      wr(32'h48, 32'h1234_5678, 4'b1111);
      wr(32'h48, 32'hAABB_CCDD, 4'b0101);
      chk(K_RD, 32'h48, 32'h12BB_56DD, "ram_odd_strb");
      chk(K_RD, 32'h3FC + 4, 32'h0, "ram_past_end");
      // Unmapped decode
      wr(32'h0, 32'h0BAD_F00D, 4'b1111);
      chk(K_RD, 32'h2000_0000, 32'h0, "unmapped_rd");
      wr(32'h2000_0000, 32'hDEAD_BEEF, 4'b1111);
      chk(K_RD, 32'h0, 32'h0BAD_F00D, "unmapped_ram0");
      chk(K_RD, 32'h40, 32'h5566_CDEF, "unmapped_ram40");
      chk(K_GPO, 0, 32'h0, "unmapped_gpo");
      chk(K_RD, MB + 8, 32'hFFFF_FFFF, "unmapped_cmp");
      wr(MB + 32'h14, 32'h1234_5678, 4'b1111);
      chk(K_RD, MB + 32'h14, 32'h0, "mmio_hole");
      // GPO and CTRL mask
      wr(MB, 32'hA5A5_A5A5, 4'b1111);
      chk(K_GPO, 0, 32'hA5A5_A5A5, "gpo_word");
      wr(MB, 32'h0000_003C, 4'b0010);
      chk(K_GPO, 0, 32'hA5A5_3CA5, "gpo_byte");
      chk(K_RD, MB, 32'hA5A5_3CA5, "gpo_rd");
      wr(MB + 12, 32'hFFFF_FFF8, 4'b1111);
      chk(K_RD, MB + 12, 32'h0, "ctrl_mask");
      // Timer with auto reload
      wr(MB + 8, 32'd3, 4'b1111);
      wr(MB + 12, 32'd3, 4'b1111);
      chk(K_RD, MB + 4, 32'd0, "tmr_c0");
      tick();
      chk(K_RD, MB + 4, 32'd1, "tmr_c1");
      tick();
      chk(K_RD, MB + 4, 32'd2, "tmr_c2");
      tick();
      chk(K_RD, MB + 4, 32'd3, "tmr_c3");
      chk(K_RD, MB + 16, 32'd0, "tmr_nomatch");
      tick();
      chk(K_RD, MB + 4, 32'd0, "tmr_reload");
      chk(K_RD, MB + 16, 32'd1, "tmr_match");
      chk(K_IRQ, 0, 32'd0, "tmr_irq_off");
      tick();
      chk(K_RD, MB + 4, 32'd1, "tmr_c1b");
      wr(MB + 12, 32'd7, 4'b0001);
      chk(K_IRQ, 0, 32'd1, "tmr_irq_on");
      chk(K_RD, MB + 4, 32'd2, "tmr_c2b");
      // W1C race: CNT reaches CMP at the next edge, W1C on that edge
      tick();
      wr(MB + 16, 32'd1, 4'b0001);
      chk(K_RD, MB + 16, 32'd1, "w1c_race_status");
      chk(K_IRQ, 0, 32'd1, "w1c_race_irq");
      chk(K_RD, MB + 4, 32'd0, "w1c_race_cnt");
      wr(MB + 16, 32'd1, 4'b0001);
      chk(K_RD, MB + 16, 32'd0, "w1c_clear");
      chk(K_IRQ, 0, 32'd0, "w1c_irq_fall");
      // Wrap and write priority
      wr(MB + 12, 32'd0, 4'b0001);
      wr(MB + 4, 32'hFFFF_FFFF, 4'b1111);
      wr(MB + 8, 32'd5, 4'b1111);
      chk(K_RD, MB + 4, 32'hFFFF_FFFF, "cnt_load");
      tick();
      chk(K_RD, MB + 4, 32'hFFFF_FFFF, "cnt_hold");
      wr(MB + 12, 32'd1, 4'b0001);
      chk(K_RD, MB + 4, 32'hFFFF_FFFF, "cnt_en_edge");
      tick();
      chk(K_RD, MB + 4, 32'd0, "cnt_wrap");
      chk(K_RD, MB + 16, 32'd0, "wrap_nomatch");
      wr(MB + 4, 32'h10, 4'b1111);
      chk(K_RD, MB + 4, 32'h10, "cnt_wr_prio");
      // Match without reload keeps counting
      wr(MB + 8, 32'h12, 4'b1111);
      chk(K_RD, MB + 4, 32'h11, "cnt_after_cmp_wr");
      tick();
      tick();
      chk(K_RD, MB + 4, 32'h13, "cnt_no_reload");
      chk(K_RD, MB + 16, 32'd1, "match_no_reload");
      wr(MB + 12, 32'd5, 4'b0001);
      chk(K_IRQ, 0, 32'd1, "irq_before_rst");
      // Mid-operation asynchronous reset
      wr(MB, 32'hA5A5_A5A5, 4'b1111);
      chk(K_GPO, 0, 32'hA5A5_A5A5, "gpo_before_rst");
      tick();
      #2 reset = 1'b1;
      chk(K_GPO, 0, 32'h0, "async_gpo");
      chk(K_IRQ, 0, 32'h0, "async_irq");
      chk(K_RD, MB + 4, 32'h0, "async_cnt");
      chk(K_RD, 32'h40, 32'h5566_CDEF, "async_ram");
      tick();
      wr(32'h40, 32'h0, 4'b1111);
      wr(MB, 32'hFFFF_FFFF, 4'b1111);
      chk(K_RD, 32'h40, 32'h5566_CDEF, "rst_ram_wr_blocked");
      chk(K_GPO, 0, 32'h0, "rst_gpo_wr_blocked");
      reset = 1'b0;
      tick();
      chk(K_RD, MB + 4, 32'h0, "post_rst_cnt");
      tick();
      tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Data-side bus responder for the single-cycle RV32I core. It sits on the far end of the load/store unit's `dAddr`/`dWdata`/`wstrb`/`dRdata` interface. It decodes each access to a word-organised data RAM or a small MMIO block, which holds a general-purpose output register and a 32-bit compare timer with a sticky match flag and an interrupt. Reads are combinational so the core completes loads in one cycle. Writes, timer counting and flag updates are clocked.

## Interface
- `RAM_DEPTH`, 256: data RAM size in 32-bit words; power of two.
- `MMIO_BASE`, 32'h1000_0000: base byte address of the MMIO block, which spans 0x20 bytes.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all MMIO state; RAM contents are not reset.
- `dAddr` in 32: byte address from the LSU.
- `dWdata` in 32: store data from the LSU, right-justified (not lane-shifted).
- `wstrb` in 4: byte-lane write enables; 4'b0000 means no write.
- `dRdata` out 32: word read data; reset value is the current combinational read.
- `gpo` out 32: GPO register; resets to 0.
- `timer_irq` out 1: `STATUS.match & CTRL.irq_en`; resets to 0.

## Operation
- Decode:
  - RAM hit when `dAddr < RAM_DEPTH*4`. Word index is `dAddr[log2(RAM_DEPTH)+1:2]`.
  - MMIO hit when `dAddr[31:5] == MMIO_BASE[31:5]`. Register offset is `dAddr[4:2]`.
  - Anything else is unmapped: reads return 0, writes are ignored.
- Reads always return the whole aligned word at `{dAddr[31:2],2'b00}`, independent of `wstrb`. The LSU does the byte/half extraction.
- Store lane steering produces `wd` from `dWdata`:
  - One-hot strobe: the selected lane gets `dWdata[7:0]`.
  - 4'b0011: lanes 1:0 get `dWdata[15:0]`.
  - 4'b1100: lanes 3:2 get `dWdata[15:0]`.
  - 4'b1111: `wd = dWdata`.
  - Any other pattern: lane i gets `dWdata[8i+7:8i]`.
- Byte write: on a rising edge with `wstrb != 0` and a hit, lane i of the target word takes `wd` lane i wherever `wstrb[i]=1`. The other lanes are unchanged.
- MMIO map (offset: register, access, reset value):
  - 0x00 GPO: RW, byte-strobed, reset 0. Drives `gpo`.
  - 0x04 CNT: RW, byte-strobed, reset 0.
  - 0x08 CMP: RW, byte-strobed, reset 32'hFFFF_FFFF.
  - 0x0C CTRL: bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`. Only bits 2:0 are writable; the rest read 0. Reset 0.
  - 0x10 STATUS: bit0 `match`, sticky and write-1-to-clear via `wstrb[0] & wd[0]`. Reset 0.
  - 0x14–0x1C: read 0, writes ignored.
- Timer, evaluated each edge using pre-edge values:
  - If a CPU write hits CNT, the merged write value is loaded. The write wins over counting and over reload.
  - Else if `en` and `CNT == CMP`: `match` is set. CNT goes to 0 if `auto_reload`, otherwise to CNT+1.
  - Else if `en`: CNT goes to CNT+1, wrapping 32'hFFFF_FFFF to 0.
  - If `en`=0: CNT holds and no match is generated.
- Simultaneous `match` set and W1C clear in the same cycle: the set wins and `match` stays 1.
- Writing CMP or CTRL takes effect for comparisons from the next edge onward.

## Timing
- Read latency: 0 cycles, combinational from `dAddr`.
- A write becomes visible on `dRdata`, `gpo` or `timer_irq` immediately after the capturing edge.
- CTRL.en written to 1 at edge k: CNT first increments at edge k+1.
- `match` rises at the edge where pre-edge CNT equals CMP. `timer_irq` follows combinationally in the same cycle.
- Asserting `reset` forces GPO, CNT, CMP, CTRL and STATUS to their reset values at once, so `gpo` and `timer_irq` drop without waiting for a clock edge. RAM contents and RAM reads are unaffected.
- While `reset` is high, no writes take effect.
- There is no backpressure: every access completes in its own cycle.

## Test plan
- RAM byte stores: write SW 0x11223344 to 0x40. Then SB `dWdata`=0x000000AB with `wstrb`=4'b0100, then SH `dWdata`=0x0000CDEF with `wstrb`=4'b0011. Reading 0x40 returns 0xCCABCDEF? No: expected 0x11ABCDEF. Then SH `dWdata`=0x00005566 with `wstrb`=4'b1100; 0x40 reads 0x55661DEF? No: expected 0x5566CDEF.
- Decode: a read of 0x2000_0000 returns 0 and a write there changes no RAM or MMIO register. A read of `MMIO_BASE`+0x08 after reset returns 0xFFFFFFFF.
- Timer with reload: CMP=3, CTRL=3'b011 (`en`, `auto_reload`). CNT sequence is 1,2,3,0,1. `match` sets on the 3→0 edge; `timer_irq` stays 0 because `irq_en`=0. Writing CTRL=3'b111 raises `timer_irq`.
- W1C race: with `match` set, write STATUS=1 on the same edge a new match occurs, and `match` stays 1. Write STATUS=1 with no match pending, and `match` clears and `timer_irq` falls.
- Wrap and write priority: CNT=0xFFFF_FFFF, CMP=5, `en`=1. After one edge CNT is 0 and `match` is 0. A write of 0x10 to CNT on an enabled cycle leaves CNT at 0x10, not 0x11.
- Mid-operation reset: GPO=0xA5A5A5A5 and timer running with `timer_irq`=1. Assert `reset` between edges: `gpo` and `timer_irq` go to 0 immediately, CNT reads 0, and a previously written RAM word still reads its old value.
